// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder: serves READ (0x03 + 24-bit address) from a word-wide backing store,
// streaming bytes MSB-first while chip select stays low, with one-word prefetch.
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              mem_req_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam int unsigned WordW = ADDR_W - 2;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

    state_e            state_q, state_d;
    logic              sck_q;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-2:0] sr_q, sr_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        dsr_q, dsr_d;
    logic              miso_q, miso_d;
    logic              mem_req_q, mem_req_d;
    logic [WordW-1:0]  mem_addr_q, mem_addr_d;
    logic [WordW-1:0]  word_addr_q, word_addr_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic [31:0]       cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
    logic              cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
    logic              out_q, out_d;
    logic              tgt_nxt_q, tgt_nxt_d;
    logic              pf_want_q, pf_want_d;

    logic              rise, fall, accept, cur_avail, nxt_avail;
    logic [31:0]       cur_word_eff, nxt_word_eff;
    logic [7:0]        cur_byte;
    logic [ADDR_W-1:0] shifted;

    assign rise         = sck_i & ~sck_q;
    assign fall         = ~sck_i & sck_q;
    assign accept       = out_q & mem_rvalid_i;
    // A word arriving in the same cycle as the fall that needs it is used directly.
    assign cur_avail    = cur_valid_q | (accept & ~tgt_nxt_q);
    assign nxt_avail    = nxt_valid_q | (accept & tgt_nxt_q);
    assign cur_word_eff = (accept && !tgt_nxt_q) ? mem_rdata_i : cur_word_q;
    assign nxt_word_eff = (accept && tgt_nxt_q) ? mem_rdata_i : nxt_word_q;
    assign cur_byte     = cur_word_eff[{idx_q, 3'b000} +: 8];
    assign shifted      = {sr_q, mosi_i};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        bit_d       = bit_q;
        dsr_d       = dsr_q;
        miso_d      = miso_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        word_addr_d = word_addr_q;
        busy_d      = busy_q;
        underrun_d  = 1'b0;
        cur_word_d  = cur_word_q;
        cur_valid_d = cur_valid_q;
        nxt_word_d  = nxt_word_q;
        nxt_valid_d = nxt_valid_q;
        out_d       = out_q;
        tgt_nxt_d   = tgt_nxt_q;
        pf_want_d   = pf_want_q;

        if (accept) begin
            out_d = 1'b0;
            if (tgt_nxt_q) begin
                nxt_word_d  = mem_rdata_i;
                nxt_valid_d = 1'b1;
            end else begin
                cur_word_d  = mem_rdata_i;
                cur_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (!ss_n_i) begin
                    state_d = StCmd;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                end
            end
            StCmd: begin
                if (rise) begin
                    sr_d  = shifted[ADDR_W-2:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = 5'd0;
                        state_d = (shifted[7:0] == CMD_READ) ? StAddr : StIgnore;
                    end
                end
            end
            StAddr: begin
                if (rise) begin
                    sr_d  = shifted[ADDR_W-2:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(ADDR_W - 1)) begin
                        state_d     = StData;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = shifted[ADDR_W-1:2];
                        word_addr_d = shifted[ADDR_W-1:2];
                        idx_d       = shifted[1:0];
                        bit_d       = 3'd0;
                        out_d       = 1'b1;
                        tgt_nxt_d   = 1'b0;
                        cur_valid_d = 1'b0;
                        nxt_valid_d = 1'b0;
                        pf_want_d   = 1'b0;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    if (bit_q == 3'd0) begin
                        if (cur_avail) begin
                            miso_d = cur_byte[7];
                            dsr_d  = {cur_byte[6:0], 1'b0};
                        end else begin
                            miso_d     = 1'b0;
                            dsr_d      = 8'd0;
                            underrun_d = 1'b1;
                        end
                        if (idx_q == 2'd3) begin
                            pf_want_d = 1'b1;
                        end
                    end else begin
                        miso_d = dsr_q[7];
                        dsr_d  = {dsr_q[6:0], 1'b0};
                    end
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            word_addr_d = word_addr_q + WordW'(1);
                            cur_word_d  = nxt_word_eff;
                            cur_valid_d = nxt_avail;
                            nxt_valid_d = 1'b0;
                            // A prefetch still in flight now belongs to the current word.
                            if (out_d && tgt_nxt_q) begin
                                tgt_nxt_d = 1'b0;
                            end
                        end
                    end
                end
            end
            StIgnore: ;
            default: state_d = StIdle;
        endcase

        if (pf_want_d && !out_d && state_d == StData) begin
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr_d + WordW'(1);
            out_d      = 1'b1;
            tgt_nxt_d  = 1'b1;
            pf_want_d  = 1'b0;
        end

        if (ss_n_i && state_q != StIdle) begin
            state_d     = StIdle;
            cnt_d       = 5'd0;
            bit_d       = 3'd0;
            idx_d       = 2'd0;
            busy_d      = 1'b0;
            miso_d      = 1'b0;
            mem_req_d   = 1'b0;
            underrun_d  = 1'b0;
            out_d       = 1'b0;
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
            pf_want_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sck_q       <= 1'b0;
            cnt_q       <= 5'd0;
            sr_q        <= '0;
            idx_q       <= 2'd0;
            bit_q       <= 3'd0;
            dsr_q       <= 8'd0;
            miso_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            word_addr_q <= '0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            cur_word_q  <= 32'd0;
            cur_valid_q <= 1'b0;
            nxt_word_q  <= 32'd0;
            nxt_valid_q <= 1'b0;
            out_q       <= 1'b0;
            tgt_nxt_q   <= 1'b0;
            pf_want_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_i;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            dsr_q       <= dsr_d;
            miso_q      <= miso_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            word_addr_q <= word_addr_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            cur_word_q  <= cur_word_d;
            cur_valid_q <= cur_valid_d;
            nxt_word_q  <= nxt_word_d;
            nxt_valid_q <= nxt_valid_d;
            out_q       <= out_d;
            tgt_nxt_q   <= tgt_nxt_d;
            pf_want_q   <= pf_want_d;
        end
    end

    assign miso_o     = miso_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI master driving READ transfers, a latency-programmable
// memory responder, and a byte-addressed reference model of the expected stream and fetches.
module tb_spi_flash_responder;

    logic        clock;
    logic        reset;
    logic        sck, ss_n, mosi, miso;
    logic        mem_req, mem_rvalid;
    logic [21:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy, underrun;

    spi_flash_responder dut (
        .clock       (clock),
        .reset       (reset),
        .sck_i       (sck),
        .ss_n_i      (ss_n),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_rvalid_i(mem_rvalid),
        .busy_o      (busy),
        .underrun_o  (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int half = 2;
    int lat = 1;
    int und_cnt = 0;
    int miso_ones = 0;
    logic [31:0] mem [int unsigned];
    int unsigned reqs[$];
    logic [7:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h0101_0107) ^ 32'hA5C3_5A3C;
    endfunction

    function automatic logic [7:0] byte_at(input int unsigned b);
        int unsigned bb;
        logic [31:0] s;
        bb = b & 32'h00FF_FFFF;
        s = word_of(bb >> 2) >> (8 * (bb & 3));
        return s[7:0];
    endfunction

    // Memory responder: answers each request after lat clocks; logs requests and underruns.
    initial begin
        int cnt;
        int unsigned pend;
        int unsigned a;
        cnt = 0;
        pend = 0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = word_of(pend);
                end
            end
            if (mem_req && !reset) begin
                a = 32'(mem_addr);
                reqs.push_back(a);
                pend = a;
                cnt = lat;
            end
            if (underrun && !reset) und_cnt++;
        end
    end

    task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int naddr,
                        input int nbytes, input int stop_at);
        int total;
        logic [7:0] acc;
        logic s;
        total = 8 + naddr + 8 * nbytes;
        acc = 8'd0;
        @(negedge clock);
        check("busy_idle", 32'(busy), 32'd0);
        ss_n = 1'b0;
        @(negedge clock);
        check("busy_rise", 32'(busy), 32'd1);
        @(negedge clock);
        for (int i = 0; i < total; i++) begin
            if (i == stop_at) return;
            if (i < 8) mosi = op[7-i];
            else if (i < 8 + naddr) mosi = addr[23-(i-8)];
            else mosi = 1'b0;
            repeat (half) @(negedge clock);
            s = miso;
            if (i >= 32 && op == 8'h03 && naddr == 24) begin
                acc = {acc[6:0], s};
                if (((i - 32) % 8) == 7) got.push_back(acc);
            end else if (s) begin
                miso_ones++;
            end
            sck = 1'b1;
            repeat (half) @(negedge clock);
            sck = 1'b0;
        end
    endtask

    task automatic end_xfer();
        repeat (2) @(negedge clock);
        check("busy_hold", 32'(busy), 32'd1);
        ss_n = 1'b1;
        @(negedge clock);
        check("busy_drop", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    // Expected fetches: the start word, then word+1 whenever a byte at offset 3 begins shifting
    // (including the byte begun by the final falling edge).
    task automatic check_read(input int unsigned a, input int n);
        int unsigned exp_q[$];
        exp_q.push_back((a >> 2) & 32'h003F_FFFF);
        for (int k = 0; k <= n; k++) begin
            if (((a + k) & 3) == 3) exp_q.push_back((((a + k) >> 2) + 1) & 32'h003F_FFFF);
        end
        check("byte_count", 32'(got.size()), 32'(n));
        for (int k = 0; k < n && k < got.size(); k++) begin
            check($sformatf("byte%0d@%0h", k, a), 32'(got[k]), 32'(byte_at(a + k)));
        end
        check("req_count", 32'(reqs.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < reqs.size(); k++) begin
            check($sformatf("req%0d@%0h", k, a), reqs[k], exp_q[k]);
        end
    endtask

    task automatic run_read(input int unsigned a, input int n);
        got.delete();
        reqs.delete();
        xfer(8'h03, a[23:0], 24, n, -1);
        end_xfer();
        check_read(a, n);
    endtask

    initial begin
        int unsigned a;
        int n;
        reset = 1'b1;
        sck = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Aligned, unaligned-crossing and wrapping reads.
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;
        mem[22'h3F_FFFF] = 32'hDDCC_BBAA;
        run_read(32'h0000_0000, 4);
        run_read(32'h0000_0002, 4);
        run_read(32'h00FF_FFFE, 3);

        // Unsupported opcode.
        reqs.delete();
        miso_ones = 0;
        xfer(8'h9F, 24'h00_0000, 24, 0, -1);
        end_xfer();
        check("ignore_req", 32'(reqs.size()), 32'd0);
        check("ignore_miso", 32'(miso_ones), 32'd0);

        // Abort after 12 address bits, then a clean read.
        reqs.delete();
        xfer(8'h03, 24'h00_0004, 12, 0, -1);
        end_xfer();
        check("abort_req", 32'(reqs.size()), 32'd0);
        run_read(32'h0000_0004, 4);

        // Randomized reads over random memory contents and SCK rates.
        for (int r = 0; r < 6; r++) begin
            half = $urandom_range(2, 4);
            a = $urandom_range(0, 32'h00FF_FFFF);
            n = $urandom_range(1, 9);
            for (int k = 0; k <= n + 4; k++) mem[((a + k) >> 2) & 32'h003F_FFFF] = $urandom;
            run_read(a, n);
        end

        // Late fetch: first byte underruns, the rest follow.
        half = 2;
        lat = 6;
        mem[0] = 32'h4433_2211;
        und_cnt = 0;
        got.delete();
        reqs.delete();
        xfer(8'h03, 24'h00_0000, 24, 4, -1);
        end_xfer();
        check("underrun_count", 32'(und_cnt), 32'd1);
        check("underrun_size", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("underrun_byte0", 32'(got[0]), 32'd0);
            for (int k = 1; k < 4; k++)
                check($sformatf("underrun_byte%0d", k), 32'(got[k]), 32'(byte_at(k)));
        end
        check("underrun_reqs", 32'(reqs.size()), 32'd2);

        // Reset in the middle of the data phase.
        lat = 1;
        got.delete();
        reqs.delete();
        xfer(8'h03, 24'h00_0104, 24, 4, 48);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_addr", 32'(mem_addr), 32'h41);
        reset = 1'b1;
        #1;
        check("mid_rst_miso", 32'(miso), 32'd0);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        ss_n = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_reset_idle", 32'(busy), 32'd0);
        a = $urandom_range(0, 32'h00FF_FFFF);
        run_read(a, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI NOR-flash responder: the device end of the flash link driven by the XIP bridge's SPI master. Lives next to the SPI master in the perip tree, wired to `spi_sck`, `spi_ss[0]` and `spi_mosi`, and drives `spi_miso`. It decodes the READ command (0x03 plus a 24-bit address), fetches 32-bit words from a backing store through a simple request/valid port, and streams bytes MSB-first for as long as SS stays asserted. SCK is generated from the same `clock`, so inputs are sampled directly without synchronizers.

## Interface
- `ADDR_W`, 24: flash byte-address width.
- `CMD_READ`, 8'h03: the only command opcode served.

- `clock`  in  1  system clock; SCK is derived from it.
- `reset`  in  1  asynchronous, active-high.
- `sck`  in  1  SPI clock, mode 0 (idle low).
- `ss_n`  in  1  chip select, active low.
- `mosi`  in  1  command/address from master.
- `miso`  out  1  data to master.
- `mem_req`  out  1  one-cycle fetch pulse.
- `mem_addr`  out  ADDR_W-2  word address of the fetch.
- `mem_rdata`  in  32  fetched word, little-endian: byte k at `[8k+7:8k]`.
- `mem_rvalid`  in  1  one-cycle pulse qualifying `mem_rdata`.
- `busy`  out  1  high while ss_n is low and the FSM is not IDLE.
- `underrun`  out  1  one-cycle pulse: a data byte was needed before its word arrived.

## Operation
- Edge detect: `sck_q` is a registered copy of `sck`. `rise = sck & ~sck_q`, `fall = ~sck & sck_q`. MOSI is sampled on `rise`. MISO is updated on `fall`.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: on `ss_n` low, go to CMD, clear the bit counter and set `busy`.
- CMD: shift in 8 bits MSB-first.
  - After the 8th `rise`: opcode == CMD_READ goes to ADDR; otherwise go to IGNORE.
- ADDR: shift in 24 bits MSB-first.
  - On the cycle after the 24th `rise`: pulse `mem_req` with `mem_addr = addr[23:2]`, latch the byte index `addr[1:0]`, go to DATA.
- DATA: load the byte `mem_rdata[8*idx+7:8*idx]` into the shift register when the word arrives.
  - On each `fall`, drive the next bit, MSB first.
  - After 8 bits, increment the byte index. Index 3 → 0 moves to the prefetched word.
  - Prefetch: when shifting of a byte with index 3 begins, pulse `mem_req` for the word address + 1, and hold the result in a one-word prefetch buffer.
  - Address wrap: word 0x3FFFFF + 1 = 0x000000 (mod 2^ADDR_W).
- IGNORE: MISO held 0; no `mem_req` is issued. Stay until `ss_n` goes high.
- `ss_n` high in any state: go to IDLE the next cycle.
  - Clear the counters, prefetch-valid flag and `busy`; drive `miso` to 0.
  - A `mem_rvalid` arriving afterwards is discarded.
- Underrun: if a `fall` needs a new byte and its word has not arrived:
  - pulse `underrun` and drive 0 for that byte;
  - the byte index still advances.
- `mem_rvalid` without an outstanding request is ignored.

## Timing
- Reset values: `miso`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `underrun`=0. The FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately. After release the block waits in IDLE until `ss_n` is low.
- `miso` changes 1 clock after SCK falls (registered on the clock edge where `fall` is seen).
- Each SCK phase must last at least 2 clocks (master divider ≥ 1).
- First data bit: driven on the `fall` that follows the 32nd `rise`. That is ≥ 2 clocks after `mem_req`, so `mem_rvalid` latency must be ≤ 2 clocks at divider 1.
- Prefetch is requested ≥ 14 clocks before it is needed.
- At most one fetch is outstanding.
- `busy` rises 1 clock after `ss_n` falls and drops 1 clock after `ss_n` rises.

## Test plan
- Aligned read: READ @0x000000, memory word 0 = 0x44332211, 32 data clocks.
  - Expect `mem_req` with `mem_addr`=0, then MISO bytes 0x11, 0x22, 0x33, 0x44, with the MSB of 0x11 on the first data `fall`.
- Unaligned read crossing a word: READ @0x000002, word 0 = 0x44332211, word 1 = 0x88776655.
  - Expect bytes 0x33, 0x44, 0x55, 0x66.
  - Expect the prefetch `mem_req` (`mem_addr`=1) during byte 0x44.
- Wrap: READ @0xFFFFFE, top word = 0xDDCCBBAA, word 0 = 0x44332211.
  - Expect 0xCC, 0xDD, 0x11, and the second `mem_req` with `mem_addr`=0.
- Unsupported opcode: 0x9F followed by 24 clocks.
  - Expect no `mem_req`, MISO constantly 0, `busy` high until `ss_n` rises.
- Abort: raise `ss_n` after 12 address bits, then perform a valid READ @0x000004.
  - Expect the first transaction to issue no `mem_req`; the second returns the correct bytes of word 1.
- Underrun and reset: delay `mem_rvalid` by 6 clocks at divider 1.
  - Expect an `underrun` pulse and first byte 0x00.
  - Assert `reset` mid-DATA: all outputs go to their reset values within the same cycle.
